// File: rtl/jsv_pkg.sv
// jsv_pkg: shared constants and types for the Julia-set pixel scheduler.
//   H_RES/V_RES   default screen geometry (640x480)
//   NUM_ENG       default iteration-engine pool size
//   COORD_W       pixel coordinate width
//   ITER_W        iteration-count width
//   pixel_t       one drawn pixel {x, y, i}
//   sched_state_t frame scheduler states
package jsv_pkg;

    localparam int H_RES   = 640;
    localparam int V_RES   = 480;
    localparam int NUM_ENG = 2;
    localparam int COORD_W = 10;
    localparam int ITER_W  = 8;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [ITER_W-1:0]  i;
    } pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } sched_state_t;

    function automatic int unsigned frame_pixels(int unsigned h, int unsigned v);
        return h * v;
    endfunction

endpackage

// File: rtl/julia_pixel_scheduler_if.sv
// julia_pixel_scheduler_if: control, engine-pool and draw-port signals of the
// pixel scheduler.
//   control : start (in), busy, frame_done (out)
//   issue   : iss_valid (one-hot), iss_x, iss_y (out); eng_ready (in)
//   result  : res_valid, res_x, res_y, res_i (in, packed per engine); res_ack (out)
//   draw    : draw, draw_x, draw_y, draw_i (out); draw_ready (in)
// master = scheduler side, slave = environment (engines, SDRAM writer, control).
interface julia_pixel_scheduler_if #(
    parameter int NUM_ENG = jsv_pkg::NUM_ENG,
    parameter int COORD_W = jsv_pkg::COORD_W,
    parameter int ITER_W  = jsv_pkg::ITER_W
);
    logic                       start;
    logic                       busy;
    logic                       frame_done;
    logic [NUM_ENG-1:0]         iss_valid;
    logic [COORD_W-1:0]         iss_x;
    logic [COORD_W-1:0]         iss_y;
    logic [NUM_ENG-1:0]         eng_ready;
    logic [NUM_ENG-1:0]         res_valid;
    logic [NUM_ENG*COORD_W-1:0] res_x;
    logic [NUM_ENG*COORD_W-1:0] res_y;
    logic [NUM_ENG*ITER_W-1:0]  res_i;
    logic [NUM_ENG-1:0]         res_ack;
    logic                       draw;
    logic [COORD_W-1:0]         draw_x;
    logic [COORD_W-1:0]         draw_y;
    logic [ITER_W-1:0]          draw_i;
    logic                       draw_ready;

    modport master (
        input  start, eng_ready, res_valid, res_x, res_y, res_i, draw_ready,
        output busy, frame_done, iss_valid, iss_x, iss_y, res_ack,
               draw, draw_x, draw_y, draw_i
    );

    modport slave (
        output start, eng_ready, res_valid, res_x, res_y, res_i, draw_ready,
        input  busy, frame_done, iss_valid, iss_x, iss_y, res_ack,
               draw, draw_x, draw_y, draw_i
    );

endinterface

// File: rtl/julia_pixel_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a registered priority pointer.
//   clk, rst : clock, asynchronous active-high reset (pointer -> 0)
//   req      : N request lines
//   advance  : the current grant is being consumed; pointer moves past it
//   grant    : one-hot grant, first requester at or after the pointer
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);
    localparam int          PW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned NU = N;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] win;
    logic          found;
    int unsigned   idx;

    always_comb begin
        grant = '0;
        win   = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < NU; k++) begin
            idx = (int'(ptr_q) + k) % NU;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                win        = PW'(idx);
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (advance && found) begin
            ptr_q <= (int'(win) == N - 1) ? '0 : win + PW'(1);
        end
    end

endmodule

// File: rtl/julia_pixel_scheduler.sv
// julia_pixel_scheduler: walks the H_RES x V_RES frame in raster order, issues
// coordinates to a pool of fractal engines and funnels their results, in
// completion order, into the single SDRAM draw port.
//   Clk, Reset_h : system clock, asynchronous active-high reset
//   bus (master) : start/busy/frame_done control, engine issue/result lanes,
//                  draw port (see julia_pixel_scheduler_if)
module julia_pixel_scheduler #(
    parameter int H_RES   = jsv_pkg::H_RES,
    parameter int V_RES   = jsv_pkg::V_RES,
    parameter int NUM_ENG = jsv_pkg::NUM_ENG,
    parameter int COORD_W = jsv_pkg::COORD_W,
    parameter int ITER_W  = jsv_pkg::ITER_W
) (
    input  logic Clk,
    input  logic Reset_h,
    julia_pixel_scheduler_if.master bus
);
    import jsv_pkg::*;

    localparam int unsigned TOTAL   = frame_pixels(H_RES, V_RES);
    localparam int          DRAWN_W = $clog2(TOTAL + 1);
    localparam int unsigned NE      = NUM_ENG;

    sched_state_t         state_q, state_d;
    logic [COORD_W-1:0]   x_q, y_q;
    logic [NUM_ENG-1:0]   outstanding_q, avail, iss, grant, ack;
    logic [DRAWN_W-1:0]   drawn_q;
    logic                 draw_q;
    logic [COORD_W-1:0]   dx_q, dy_q, win_x, win_y;
    logic [ITER_W-1:0]    di_q, win_i;
    logic                 start_ok, issuing, last_issue, handshake, capture;

    assign start_ok   = (state_q == IDLE) && bus.start;
    // An engine that still owes a result is never offered new work.
    assign avail      = bus.eng_ready & ~outstanding_q;
    assign issuing    = |iss;
    assign last_issue = issuing && (x_q == COORD_W'(H_RES - 1)) && (y_q == COORD_W'(V_RES - 1));
    assign handshake  = draw_q & bus.draw_ready;
    // The draw register takes a new result when empty or emptying this cycle.
    assign capture    = (|bus.res_valid) && (!draw_q || bus.draw_ready);
    assign ack        = capture ? grant : '0;

    rr_arbiter #(.N(NUM_ENG)) u_rr (
        .clk     (Clk),
        .rst     (Reset_h),
        .req     (bus.res_valid),
        .advance (capture),
        .grant   (grant)
    );

    // Lowest-index free engine takes the current pixel.
    always_comb begin
        iss = '0;
        if (state_q == ISSUE) begin
            for (int unsigned e = 0; e < NE; e++) begin
                if (avail[e] && (iss == '0)) iss[e] = 1'b1;
            end
        end
    end

    always_comb begin
        win_x = '0;
        win_y = '0;
        win_i = '0;
        for (int unsigned e = 0; e < NE; e++) begin
            if (grant[e]) begin
                win_x = bus.res_x[e*COORD_W +: COORD_W];
                win_y = bus.res_y[e*COORD_W +: COORD_W];
                win_i = bus.res_i[e*ITER_W +: ITER_W];
            end
        end
    end

    // DONE is entered on the final handshake itself so frame_done lands in the
    // very next cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = ISSUE;
            ISSUE:   if (last_issue) state_d = DRAIN;
            DRAIN:   if ((handshake && (drawn_q == DRAWN_W'(TOTAL - 1))) ||
                         (drawn_q == DRAWN_W'(TOTAL))) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset_h) begin
        if (Reset_h) begin
            state_q       <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            outstanding_q <= '0;
            drawn_q       <= '0;
            draw_q        <= 1'b0;
            dx_q          <= '0;
            dy_q          <= '0;
            di_q          <= '0;
        end else begin
            state_q       <= state_d;
            // Ack and re-issue to one engine in the same cycle leaves it outstanding.
            outstanding_q <= (outstanding_q & ~ack) | iss;

            if (start_ok) begin
                x_q <= '0;
                y_q <= '0;
            end else if (issuing) begin
                if (x_q == COORD_W'(H_RES - 1)) begin
                    x_q <= '0;
                    y_q <= (y_q == COORD_W'(V_RES - 1)) ? '0 : y_q + COORD_W'(1);
                end else begin
                    x_q <= x_q + COORD_W'(1);
                end
            end

            if (start_ok)       drawn_q <= '0;
            else if (handshake) drawn_q <= drawn_q + DRAWN_W'(1);

            if (capture) begin
                draw_q <= 1'b1;
                dx_q   <= win_x;
                dy_q   <= win_y;
                di_q   <= win_i;
            end else if (handshake) begin
                draw_q <= 1'b0;
            end
        end
    end

    assign bus.busy       = (state_q == ISSUE) || (state_q == DRAIN);
    assign bus.frame_done = (state_q == DONE);
    assign bus.iss_valid  = iss;
    assign bus.iss_x      = x_q;
    assign bus.iss_y      = y_q;
    assign bus.res_ack    = ack;
    assign bus.draw       = draw_q;
    assign bus.draw_x     = dx_q;
    assign bus.draw_y     = dy_q;
    assign bus.draw_i     = di_q;

endmodule

// File: tb/tb_julia_pixel_scheduler.sv
// tb_julia_pixel_scheduler: directed bench for julia_pixel_scheduler on a 4x2
// frame with two modelled fractal engines (fixed or random latency).
module tb_julia_pixel_scheduler;
    localparam int H  = 4;
    localparam int V  = 2;
    localparam int NE = 2;
    localparam int CW = 10;
    localparam int IW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    julia_pixel_scheduler_if #(.NUM_ENG(NE), .COORD_W(CW), .ITER_W(IW)) bus ();

    julia_pixel_scheduler #(
        .H_RES(H), .V_RES(V), .NUM_ENG(NE), .COORD_W(CW), .ITER_W(IW)
    ) dut (
        .Clk     (clk),
        .Reset_h (rst),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- engine models ----------------
    int       lat       = 3;
    bit       lat_rand  = 1'b0;
    bit       force_res = 1'b0;
    logic [1:0]    est  [NE];   // 0 idle, 1 computing, 2 result held
    int            ecnt [NE];
    logic [CW-1:0] ex   [NE];
    logic [CW-1:0] ey   [NE];

    function automatic logic [IW-1:0] iter_of(logic [CW-1:0] x, logic [CW-1:0] y);
        return IW'(x) * 8'd8 + IW'(y) * 8'd3 + 8'd1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < NE; e++) begin
                est[e]  <= 2'd0;
                ecnt[e] <= 0;
                ex[e]   <= '0;
                ey[e]   <= '0;
            end
        end else begin
            for (int e = 0; e < NE; e++) begin
                case (est[e])
                    2'd0: if (bus.iss_valid[e]) begin
                        ex[e]   <= bus.iss_x;
                        ey[e]   <= bus.iss_y;
                        ecnt[e] <= lat_rand ? int'($urandom_range(1, 20)) : lat;
                        est[e]  <= 2'd1;
                    end
                    2'd1: if (ecnt[e] <= 1) est[e] <= 2'd2;
                          else ecnt[e] <= ecnt[e] - 1;
                    default: if (bus.res_ack[e]) est[e] <= 2'd0;
                endcase
            end
        end
    end

    always_comb begin
        bus.eng_ready = '0;
        bus.res_valid = '0;
        bus.res_x     = '0;
        bus.res_y     = '0;
        bus.res_i     = '0;
        for (int e = 0; e < NE; e++) begin
            bus.eng_ready[e] = (est[e] == 2'd0);
            bus.res_valid[e] = force_res || (est[e] == 2'd2);
            bus.res_x[e*CW +: CW] = force_res ? CW'(5 + 4 * e) : ex[e];
            bus.res_y[e*CW +: CW] = force_res ? CW'(1 + e) : ey[e];
            bus.res_i[e*IW +: IW] = iter_of(bus.res_x[e*CW +: CW], bus.res_y[e*CW +: CW]);
        end
    end

    // ---------------- observation log ----------------
    int iss_n, draw_n, done_n, bad_i, dbl_iss, done_busy;
    logic [CW-1:0] iss_xl[$];
    logic [CW-1:0] iss_yl[$];
    int seen [H*V];

    always @(posedge clk) begin
        if (!rst) begin
            if (bus.iss_valid != '0) begin
                iss_n++;
                iss_xl.push_back(bus.iss_x);
                iss_yl.push_back(bus.iss_y);
                if ($countones(bus.iss_valid) != 1) dbl_iss++;
                for (int e = 0; e < NE; e++)
                    if (bus.iss_valid[e] && est[e] != 2'd0) dbl_iss++;
            end
            if (bus.draw && bus.draw_ready) begin
                draw_n++;
                if (int'(bus.draw_x) < H && int'(bus.draw_y) < V)
                    seen[int'(bus.draw_y) * H + int'(bus.draw_x)]++;
                else
                    bad_i++;
                if (bus.draw_i != iter_of(bus.draw_x, bus.draw_y)) bad_i++;
            end
            if (bus.frame_done) begin
                done_n++;
                if (bus.busy) done_busy++;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        iss_n = 0; draw_n = 0; done_n = 0; bad_i = 0; dbl_iss = 0; done_busy = 0;
        iss_xl.delete();
        iss_yl.delete();
        for (int p = 0; p < H * V; p++) seen[p] = 0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d0;
        int t;
        d0 = done_n;
        t  = 0;
        while (done_n == d0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk(tag, done_n, d0 + 1);
    endtask

    task automatic chk_pixels_once(input string tag);
        int bad;
        bad = 0;
        for (int p = 0; p < H * V; p++) if (seen[p] != 1) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int t;
        logic [CW-1:0] hx, hy;
        logic [IW-1:0] hi;
        int hold_bad, ack_bad;

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.draw_ready = 1'b1;
        clear_log();
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_busy",       bus.busy,       0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_iss_valid",  bus.iss_valid,  0);
        chk("rst_draw",       bus.draw,       0);
        chk("rst_res_ack",    bus.res_ack,    0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // tiny frame, latency 3, draw_ready high
        clear_log();
        lat = 3;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_busy",      bus.busy,      1);
        chk("first_iss_valid", bus.iss_valid, 2'b01);
        chk("first_iss_x",     bus.iss_x,     0);
        chk("first_iss_y",     bus.iss_y,     0);
        wait_done(200, "frame1_done");
        chk("frame1_draws",  draw_n, 8);
        chk("frame1_issues", iss_n,  8);
        for (int k = 0; k < 8; k++) begin
            if (k < iss_xl.size()) begin
                chk($sformatf("issue_order_x%0d", k), iss_xl[k], k % H);
                chk($sformatf("issue_order_y%0d", k), iss_yl[k], k / H);
            end
        end
        chk_pixels_once("frame1_pixel_once");
        chk("frame1_draw_data", bad_i,     0);
        chk("frame1_dbl_issue", dbl_iss,   0);
        chk("frame1_done_busy", done_busy, 0);
        repeat (5) @(negedge clk);
        chk("frame1_single_done", done_n,   1);
        chk("frame1_idle_busy",   bus.busy, 0);

        // back-pressure
        clear_log();
        bus.draw_ready = 1'b0;
        pulse_start();
        t = 0;
        while (!bus.draw && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("bp_draw_seen", bus.draw, 1);
        hx = bus.draw_x;
        hy = bus.draw_y;
        hi = bus.draw_i;
        hold_bad = 0;
        ack_bad  = 0;
        repeat (10) begin
            @(negedge clk);
            if (!bus.draw || bus.draw_x != hx || bus.draw_y != hy || bus.draw_i != hi) hold_bad++;
            if (bus.res_ack != '0) ack_bad++;
        end
        chk("bp_hold_stable", hold_bad, 0);
        chk("bp_no_ack",      ack_bad,  0);
        chk("bp_no_draws",    draw_n,   0);
        bus.draw_ready = 1'b1;
        wait_done(300, "bp_done");
        chk("bp_draws", draw_n, 8);
        chk_pixels_once("bp_pixel_once");
        chk("bp_draw_data", bad_i, 0);

        // arbitration: both results pending every cycle, pointer from reset
        @(negedge clk);
        rst = 1'b1;
        force_res = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arb_grant0", bus.res_ack, 2'b01);
        @(negedge clk);
        chk("arb_grant1", bus.res_ack, 2'b10);
        chk("arb_draw1_x", bus.draw_x, 5);
        chk("arb_draw1_y", bus.draw_y, 1);
        @(negedge clk);
        chk("arb_grant2", bus.res_ack, 2'b01);
        chk("arb_draw2_x", bus.draw_x, 9);
        chk("arb_draw2_y", bus.draw_y, 2);
        @(negedge clk);
        chk("arb_grant3", bus.res_ack, 2'b10);
        chk("arb_draw3_x", bus.draw_x, 5);
        chk("arb_draw3_i", bus.draw_i, iter_of(10'd5, 10'd1));

        // start pulsed during DRAIN is ignored
        @(negedge clk);
        rst = 1'b1;
        force_res = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        clear_log();
        lat = 3;
        pulse_start();
        t = 0;
        while (iss_n < 8 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain_all_issued", iss_n, 8);
        chk("drain_busy",       bus.busy, 1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(200, "drain_done");
        chk("drain_draws", draw_n, 8);
        chk_pixels_once("drain_pixel_once");
        repeat (20) @(negedge clk);
        chk("drain_single_done", done_n,   1);
        chk("drain_idle_busy",   bus.busy, 0);

        // random engine latency
        clear_log();
        lat_rand = 1'b1;
        pulse_start();
        wait_done(1000, "rand_done");
        chk("rand_draws", draw_n, 8);
        chk_pixels_once("rand_pixel_once");
        chk("rand_draw_data", bad_i,   0);
        chk("rand_dbl_issue", dbl_iss, 0);
        lat_rand = 1'b0;

        // reset mid-ISSUE while a draw is pending
        clear_log();
        lat = 1;
        bus.draw_ready = 1'b0;
        pulse_start();
        t = 0;
        while (!bus.draw && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("mid_draw_pending", bus.draw, 1);
        chk("mid_still_issuing", (iss_n < 8) ? 1 : 0, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy",      bus.busy,       0);
        chk("mid_rst_draw",      bus.draw,       0);
        chk("mid_rst_iss_valid", bus.iss_valid,  0);
        chk("mid_rst_done",      bus.frame_done, 0);
        chk("mid_rst_ack",       bus.res_ack,    0);
        @(negedge clk);
        rst = 1'b0;
        bus.draw_ready = 1'b1;
        clear_log();
        repeat (10) @(negedge clk);
        chk("mid_no_issue", iss_n,  0);
        chk("mid_no_draw",  draw_n, 0);
        chk("mid_no_done",  done_n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/julia_pixel_scheduler.md
# julia_pixel_scheduler

Frame-level scheduler that walks the 640x480 screen in raster order, dispatches pixel coordinates to a pool of `fractal_calc` iteration engines, and funnels their results into the single SDRAM bitmap draw port. It sits between the keyboard/ISM control path (`start`) and the `vga_interface_bitmap_input_sdram_*` port, owning both the engine pool and the draw port.

## Interface
- `H_RES`, 640, pixels per line
- `V_RES`, 480, lines per frame
- `NUM_ENG`, 2, number of iteration engines (1..8)
- `COORD_W`, 10, coordinate width
- `ITER_W`, 8, iteration-count width
- `Clk`  in  1  system clock (50 MHz)
- `Reset_h`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle request to render a frame
- `busy`  out  1  high from accepted `start` until `frame_done`
- `frame_done`  out  1  one-cycle pulse after the last pixel is drawn
- `iss_valid`  out  `NUM_ENG`  one-hot issue strobe to engine e
- `iss_x`, `iss_y`  out  `COORD_W` each  pixel coordinate issued (shared bus)
- `eng_ready`  in  `NUM_ENG`  engine e idle and able to accept
- `res_valid`  in  `NUM_ENG`  engine e holds a finished result
- `res_x`, `res_y`  in  `NUM_ENG*COORD_W` each  packed result coordinates
- `res_i`  in  `NUM_ENG*ITER_W`  packed iteration counts
- `res_ack`  out  `NUM_ENG`  result of engine e consumed this cycle
- `draw`  out  1  draw-port data valid
- `draw_x`, `draw_y`  out  `COORD_W` each  pixel to write
- `draw_i`  out  `ITER_W`  iteration count to write
- `draw_ready`  in  1  SDRAM writer accepts this cycle

## Operation
- FSM: IDLE -> (start) -> ISSUE -> (last pixel issued) -> DRAIN -> (drawn count == H_RES*V_RES) -> DONE -> IDLE. DONE lasts exactly one cycle and drives `frame_done`.
- `start` is ignored outside IDLE.
- ISSUE: each cycle, the lowest-index e with `eng_ready[e]` receives `iss_valid[e]=1` and the current (x,y). x increments, wraps at H_RES-1 to 0 and increments y. At most one issue per cycle.
- An engine is never issued to twice without returning a result. The scheduler keeps a per-engine outstanding bit, set on issue and cleared on `res_ack`, and ANDs it out of `eng_ready`.
- Result side: a round-robin arbiter (pointer advances past the last winner) picks among `res_valid`. The winner is captured into the draw register when the register is empty or drains this cycle (`draw & draw_ready`). `res_ack[winner]` is asserted in that same cycle, combinationally.
- Draw register holds `draw`, `draw_x`, `draw_y`, `draw_i` stable until `draw_ready`.
- Drawn counter width is `$clog2(H_RES*V_RES+1)`, 19 bits at default. It increments on each `draw & draw_ready`. Issue and drawn counters clear on `start` acceptance.
- Results are written in completion order, not raster order.

## Timing
- All outputs reset to 0; FSM to IDLE; RR pointer to 0; counters to 0.
- `start` accepted at edge N: `busy`=1 after N; first `iss_valid` in cycle N+1 if any engine is ready.
- Result to draw latency: `res_valid` at cycle N with free register -> `draw`=1 from cycle N+1.
- Throughput: one draw per cycle when `draw_ready` is held high and results are available.
- Simultaneous `res_ack` and issue to the same engine in one cycle are allowed: the outstanding bit clears and sets, net 1.
- `frame_done` pulses the cycle after the final draw handshake; `busy` drops in that same cycle.
- Reset mid-frame aborts immediately. No partial draw completes. Engines share `Reset_h`.

## Structure
- `jsv_pkg`: H_RES/V_RES/COORD_W/ITER_W constants, `pixel_t` struct {x, y, i}, `sched_state_t` enum {IDLE, ISSUE, DRAIN, DONE}.
- One sub-module: `rr_arbiter` (parameter N; `req`, `advance` in; one-hot `grant` out; registered pointer).

## Test plan
- Reset: assert `Reset_h` mid-ISSUE with `draw`=1 -> all outputs 0 next edge, `busy`=0, no further `iss_valid`.
- Tiny frame, H_RES=4, V_RES=2, NUM_ENG=2, engines reply after 3 cycles, `draw_ready`=1 -> issue order (0,0),(1,0),(2,0),(3,0),(0,1)...; 8 draws; one `frame_done`.
- Back-pressure: `draw_ready`=0 for 10 cycles -> draw fields held constant, `res_ack` stays 0, no result lost; count still 8.
- Arbitration: both `res_valid` set every cycle -> grants alternate e0, e1, e0; no starvation.
- Ignored start: pulse `start` during DRAIN -> no counter reset, single `frame_done`.
- Full default frame, NUM_ENG=2, random engine latency 1..255 -> exactly 307200 draws, each (x,y) exactly once, then `frame_done`.
